// File: rtl/ltssm_polling_fsm.sv
// ltssm_polling_fsm: PCIe LTSSM Polling sub-state machine.
// Drives TS1/TS2 transmit requests. Counts sent and received training sets.
// Reports success (go to Configuration), failure (back to Detect) or entry
// into Polling.Compliance.
//
// Interface semantics: the design has no valid/ready handshake. Every input
// is a strobe sampled on each rising clk_i edge.
//   - ts_valid_i / os_sent_i report one event per cycle while high.
//   - ts_type_i / ts_compliance_i are meaningful only while ts_valid_i is high.
//   - tx_os_req_o is a level. The transmitter keeps sending while it is high.
//   - substate_o is the registered FSM state, visible for debug and checking.
module ltssm_polling_fsm #(
  parameter int unsigned TIMEOUT_ACTIVE = 6000000,
  parameter int unsigned TIMEOUT_CONFIG = 12000000,
  parameter int unsigned TX_TS1_MIN     = 1024,
  parameter int unsigned RX_TS_REQ      = 8,
  parameter int unsigned TX_TS2_AFTER   = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enter_i,
  input  logic       abort_i,
  input  logic       ts_valid_i,
  input  logic       ts_type_i,
  input  logic       ts_compliance_i,
  input  logic       os_sent_i,
  output logic       tx_os_req_o,
  output logic       tx_os_type_o,
  output logic       compliance_o,
  output logic [1:0] substate_o,
  output logic       done_o,
  output logic       fail_o
);

  localparam int unsigned TMR_MAX = (TIMEOUT_ACTIVE > TIMEOUT_CONFIG) ? TIMEOUT_ACTIVE
                                                                      : TIMEOUT_CONFIG;
  localparam int TX_W  = $clog2(TX_TS1_MIN) + 1;
  localparam int RX_W  = $clog2(RX_TS_REQ) + 1;
  localparam int TX2_W = $clog2(TX_TS2_AFTER) + 1;
  localparam int TMR_W = $clog2(TMR_MAX) + 1;

  localparam logic [TX_W-1:0]  TX_MIN_C   = TX_W'(TX_TS1_MIN);
  localparam logic [RX_W-1:0]  RX_REQ_C   = RX_W'(RX_TS_REQ);
  localparam logic [TX2_W-1:0] TX2_REQ_C  = TX2_W'(TX_TS2_AFTER);
  localparam logic [TMR_W-1:0] ACT_LAST_C = TMR_W'(TIMEOUT_ACTIVE - 1);
  localparam logic [TMR_W-1:0] CFG_LAST_C = TMR_W'(TIMEOUT_CONFIG - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_CONFIG = 2'd2,
    S_COMPL  = 2'd3
  } state_t;

  state_t             r_state;
  logic [TX_W-1:0]    r_tx_cnt;
  logic [RX_W-1:0]    r_rx_cnt;
  logic [TX2_W-1:0]   r_tx2_cnt;
  logic [TMR_W-1:0]   r_timer;
  logic               r_rx_seen;
  logic               r_tx_req;
  logic               r_tx_type;
  logic               r_compl;
  logic               r_done;
  logic               r_fail;

  state_t             w_nxt_state;
  logic               w_set_done;
  logic               w_set_fail;
  logic               w_restart;
  logic               w_act_ok;
  logic               w_cfg_ok;
  logic               w_ts2_rx;
  logic               w_tx_sat;
  logic               w_rx_sat;
  logic               w_tx2_sat;
  logic               w_tmr_sat;

  // Exit conditions look only at registered counters, so a set that arrives
  // in the same cycle is seen one edge later.
  assign w_act_ok  = (r_tx_cnt >= TX_MIN_C) && (r_rx_cnt >= RX_REQ_C);
  assign w_cfg_ok  = (r_rx_cnt >= RX_REQ_C) && (r_tx2_cnt >= TX2_REQ_C);
  assign w_ts2_rx  = ts_valid_i && ts_type_i;
  assign w_tx_sat  = &r_tx_cnt;
  assign w_rx_sat  = &r_rx_cnt;
  assign w_tx2_sat = &r_tx2_cnt;
  assign w_tmr_sat = &r_timer;

  // Next-state selection. Priority is abort, then enter, then success, then timeout.
  always_comb begin
    w_nxt_state = r_state;
    w_set_done  = 1'b0;
    w_set_fail  = 1'b0;
    if (abort_i) begin
      w_nxt_state = S_IDLE;
    end else if (enter_i) begin
      w_nxt_state = S_ACTIVE;
    end else begin
      case (r_state)
        S_ACTIVE: begin
          if (w_act_ok) begin
            w_nxt_state = S_CONFIG;
          end else if (r_timer == ACT_LAST_C) begin
            // A completely silent link goes to Compliance. A link that was
            // heard but never qualified counts as a failed attempt.
            if (!r_rx_seen) begin
              w_nxt_state = S_COMPL;
            end else begin
              w_nxt_state = S_IDLE;
              w_set_fail  = 1'b1;
            end
          end
        end
        S_CONFIG: begin
          if (w_cfg_ok) begin
            w_nxt_state = S_IDLE;
            w_set_done  = 1'b1;
          end else if (r_timer == CFG_LAST_C) begin
            w_nxt_state = S_IDLE;
            w_set_fail  = 1'b1;
          end
        end
        S_COMPL: begin
          if (ts_valid_i) begin
            w_nxt_state = S_ACTIVE;
          end
        end
        default: begin
          w_nxt_state = r_state;
        end
      endcase
    end
    // enter_i restarts ACTIVE even when the state is already ACTIVE.
    w_restart = (w_nxt_state != r_state) || (enter_i && !abort_i);
  end

  // State, registered outputs, counters and timer. Events in a cycle that
  // changes state are dropped and the counters restart from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_tx_cnt  <= '0;
      r_rx_cnt  <= '0;
      r_tx2_cnt <= '0;
      r_timer   <= '0;
      r_rx_seen <= 1'b0;
      r_tx_req  <= 1'b0;
      r_tx_type <= 1'b0;
      r_compl   <= 1'b0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_done    <= w_set_done;
      r_fail    <= w_set_fail;
      r_tx_req  <= (w_nxt_state == S_ACTIVE) || (w_nxt_state == S_CONFIG);
      r_tx_type <= (w_nxt_state == S_CONFIG);
      r_compl   <= (w_nxt_state == S_COMPL);
      if (w_restart) begin
        r_tx_cnt  <= '0;
        r_rx_cnt  <= '0;
        r_tx2_cnt <= '0;
        r_timer   <= '0;
        r_rx_seen <= 1'b0;
      end else begin
        case (r_state)
          S_ACTIVE: begin
            if (!w_tmr_sat) r_timer <= r_timer + 1'b1;
            if (os_sent_i && !w_tx_sat) r_tx_cnt <= r_tx_cnt + 1'b1;
            if (ts_valid_i) begin
              r_rx_seen <= 1'b1;
              // A compliance-flagged TS breaks the consecutive run.
              if (ts_compliance_i) begin
                r_rx_cnt <= '0;
              end else if (!w_rx_sat) begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
              end
            end
          end
          S_CONFIG: begin
            if (!w_tmr_sat) r_timer <= r_timer + 1'b1;
            if (ts_valid_i) begin
              if (ts_type_i) begin
                if (!w_rx_sat) r_rx_cnt <= r_rx_cnt + 1'b1;
              end else begin
                r_rx_cnt <= '0;
              end
            end
            if (w_ts2_rx) r_rx_seen <= 1'b1;
            // TS2 sends count from the first received TS2 onwards. A send in
            // the same cycle as that first TS2 also counts.
            if (os_sent_i && (r_rx_seen || w_ts2_rx) && !w_tx2_sat) begin
              r_tx2_cnt <= r_tx2_cnt + 1'b1;
            end
          end
          default: begin
            r_timer <= '0;
          end
        endcase
      end
    end
  end

  assign tx_os_req_o  = r_tx_req;
  assign tx_os_type_o = r_tx_type;
  assign compliance_o = r_compl;
  assign substate_o   = r_state;
  assign done_o       = r_done;
  assign fail_o       = r_fail;

endmodule
